// File: rtl/huffman_pkg.sv
// huffman_pkg: shared FSM states and field widths for the Huffman table builder.
package huffman_pkg;
    typedef enum logic [2:0] {COUNT, INIT, FIND, MERGE, DONE} state_t;
    localparam int LEN_W = 4;
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int SLOT_W = slot_w(6);
endpackage

// File: rtl/huffman_min2_sel.sv
// huffman_min2_sel: picks the two lightest active slots, lowest index winning ties.
module huffman_min2_sel #(
    parameter int NSYM  = 6,
    parameter int CNT_W = 8,
    parameter int SW    = 3
) (
    input  logic [NSYM*CNT_W-1:0] i_w,
    input  logic [NSYM-1:0]       i_act,
    output logic [SW-1:0]         o_a,
    output logic [SW-1:0]         o_b
);
    logic [CNT_W-1:0] w_wa, w_wb;
    logic             w_fa, w_fb;
    always_comb begin
        o_a  = '0;
        o_b  = '0;
        w_wa = '0;
        w_wb = '0;
        w_fa = 1'b0;
        w_fb = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            if (i_act[i] && (!w_fa || i_w[i*CNT_W +: CNT_W] < w_wa)) begin
                o_a  = SW'(i);
                w_wa = i_w[i*CNT_W +: CNT_W];
                w_fa = 1'b1;
            end
        end
        for (int i = 0; i < NSYM; i++) begin
            if (i_act[i] && SW'(i) != o_a && (!w_fb || i_w[i*CNT_W +: CNT_W] < w_wb)) begin
                o_b  = SW'(i);
                w_wb = i_w[i*CNT_W +: CNT_W];
                w_fb = 1'b1;
            end
        end
    end
endmodule

// File: rtl/huffman_gen_encoder.sv
// huffman_gen_encoder: counts a frame of samples per symbol, then builds a Huffman
// code by repeatedly merging the two lightest active slots (one FIND/MERGE pair each).
module huffman_gen_encoder
    import huffman_pkg::*;
#(
    parameter int NSYM   = 6,
    parameter int DATA_W = 8,
    parameter int NSAMP  = 100,
    parameter int CNT_W  = 8,
    parameter int CODE_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   cnt_valid,
    output logic [NSYM*CNT_W-1:0]  cnt_o,
    output logic                   code_valid,
    output logic [NSYM*CODE_W-1:0] code_o,
    output logic [NSYM*LEN_W-1:0]  len_o,
    output logic [NSYM*CODE_W-1:0] mask_o,
    output logic                   oor_o
);
    localparam int SW = slot_w(NSYM);
    localparam int NW = $clog2(NSAMP + 1);

    state_t            r_state;
    logic [NW-1:0]     r_n;
    logic              r_oor;
    logic [SW:0]       r_left;
    logic [SW-1:0]     r_a, r_b;
    logic [CNT_W-1:0]  r_cnt  [NSYM];
    logic [CNT_W-1:0]  r_w    [NSYM];
    logic [NSYM-1:0]   r_act;
    logic [SW-1:0]     r_grp  [NSYM];
    logic [CODE_W-1:0] r_code [NSYM];
    logic [LEN_W-1:0]  r_len  [NSYM];

    logic              w_acc, w_last, w_inr, w_to_done;
    logic [SW:0]       w_k;
    logic [SW-1:0]     w_a, w_b, w_m;
    logic [NSYM*CNT_W-1:0] w_wflat;
    logic [CNT_W-1:0]  w_cnt_n  [NSYM];
    logic [CNT_W-1:0]  w_w_n    [NSYM];
    logic [NSYM-1:0]   w_act_n;
    logic [SW-1:0]     w_grp_n  [NSYM];
    logic [CODE_W-1:0] w_code_n [NSYM];
    logic [LEN_W-1:0]  w_len_n  [NSYM];

    assign w_acc     = in_valid && in_ready;
    assign w_last    = w_acc && r_n == NW'(NSAMP - 1);
    assign w_inr     = in_data != '0 && in_data <= DATA_W'(NSYM);
    assign w_m       = (r_a < r_b) ? r_a : r_b;
    assign w_to_done = (r_state == INIT && w_k < (SW+1)'(2)) || (r_state == MERGE && r_left == (SW+1)'(2));

    huffman_min2_sel #(.NSYM(NSYM), .CNT_W(CNT_W), .SW(SW)) u_sel (
        .i_w   (w_wflat),
        .i_act (r_act),
        .o_a   (w_a),
        .o_b   (w_b)
    );

    always_comb begin
        w_k = '0;
        for (int i = 0; i < NSYM; i++) begin
            w_k = w_k + (SW+1)'(r_cnt[i] != '0);
        end
        for (int i = 0; i < NSYM; i++) begin
            w_wflat[i*CNT_W +: CNT_W] = r_w[i];
            w_cnt_n[i]  = r_cnt[i] + CNT_W'(w_acc && in_data == DATA_W'(i + 1));
            w_w_n[i]    = r_w[i];
            w_act_n[i]  = r_act[i];
            w_grp_n[i]  = r_grp[i];
            w_code_n[i] = r_code[i];
            w_len_n[i]  = r_len[i];
            if (r_state == INIT) begin
                w_w_n[i]    = r_cnt[i];
                w_act_n[i]  = r_cnt[i] != '0;
                w_grp_n[i]  = SW'(i);
                w_code_n[i] = '0;
                w_len_n[i]  = LEN_W'(w_k == (SW+1)'(1) && r_cnt[i] != '0);
            end else if (r_state == MERGE) begin
                w_w_n[i]   = (SW'(i) == w_m) ? r_w[r_a] + r_w[r_b] : r_w[i];
                w_act_n[i] = (r_act[i] && SW'(i) != r_a && SW'(i) != r_b) || SW'(i) == w_m;
                // Group A takes the 1 bit, group B the 0 bit, both become group m.
                if (r_grp[i] == r_a || r_grp[i] == r_b) begin
                    w_code_n[i] = r_code[i] | ((r_grp[i] == r_a) ? (CODE_W'(1) << r_len[i]) : '0);
                    w_len_n[i]  = r_len[i] + LEN_W'(1);
                    w_grp_n[i]  = w_m;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= COUNT;
            in_ready   <= 1'b1;
            cnt_valid  <= 1'b0;
            code_valid <= 1'b0;
            cnt_o      <= '0;
            code_o     <= '0;
            len_o      <= '0;
            mask_o     <= '0;
            oor_o      <= 1'b0;
            r_n        <= '0;
            r_oor      <= 1'b0;
            r_left     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_act      <= '0;
            for (int i = 0; i < NSYM; i++) begin
                r_cnt[i]  <= '0;
                r_w[i]    <= '0;
                r_grp[i]  <= '0;
                r_code[i] <= '0;
                r_len[i]  <= '0;
            end
        end else begin
            cnt_valid  <= 1'b0;
            code_valid <= 1'b0;
            r_act      <= w_act_n;
            for (int i = 0; i < NSYM; i++) begin
                r_w[i]    <= w_w_n[i];
                r_grp[i]  <= w_grp_n[i];
                r_code[i] <= w_code_n[i];
                r_len[i]  <= w_len_n[i];
            end
            case (r_state)
                COUNT: begin
                    for (int i = 0; i < NSYM; i++) r_cnt[i] <= w_cnt_n[i];
                    r_oor <= r_oor | (w_acc && !w_inr);
                    r_n   <= w_last ? '0 : r_n + NW'(w_acc);
                    if (w_last) begin
                        for (int i = 0; i < NSYM; i++) cnt_o[i*CNT_W +: CNT_W] <= w_cnt_n[i];
                        cnt_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        r_state   <= INIT;
                    end
                end
                INIT: begin
                    r_left  <= w_k;
                    r_state <= w_to_done ? DONE : FIND;
                end
                FIND: begin
                    r_a     <= w_a;
                    r_b     <= w_b;
                    r_state <= MERGE;
                end
                MERGE: begin
                    r_left  <= r_left - (SW+1)'(1);
                    r_state <= w_to_done ? DONE : FIND;
                end
                default: begin
                    for (int i = 0; i < NSYM; i++) r_cnt[i] <= '0;
                    r_oor    <= 1'b0;
                    in_ready <= 1'b1;
                    r_state  <= COUNT;
                end
            endcase
            // Outputs are loaded on the edge entering DONE so code_valid is seen in DONE.
            if (w_to_done) begin
                code_valid <= 1'b1;
                oor_o      <= r_oor;
                for (int i = 0; i < NSYM; i++) begin
                    code_o[i*CODE_W +: CODE_W] <= w_code_n[i];
                    len_o[i*LEN_W +: LEN_W]    <= w_len_n[i];
                    mask_o[i*CODE_W +: CODE_W] <= (CODE_W'(1) << w_len_n[i]) - CODE_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_huffman_gen_encoder.sv
// tb_huffman_gen_encoder: directed frames with hand-computed Huffman tables.
module tb_huffman_gen_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, cnt_valid, code_valid, oor_o;
    logic [47:0] cnt_o, code_o, mask_o;
    logic [23:0] len_o;

    logic        v8 = 1'b0;
    logic [7:0]  d8 = '0;
    logic        rdy8, cv8, kv8, oor8;
    logic [63:0] cnt8, code8, mask8;
    logic [31:0] len8;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  q[$];
    logic [47:0] cap_cnt, cap_code, cap_mask;
    logic [23:0] cap_len;
    logic        cap_oor;
    int          lat;

    always #5 clk = ~clk;

    huffman_gen_encoder u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .cnt_valid(cnt_valid), .cnt_o(cnt_o),
        .code_valid(code_valid), .code_o(code_o), .len_o(len_o),
        .mask_o(mask_o), .oor_o(oor_o)
    );

    huffman_gen_encoder #(.NSYM(8), .NSAMP(96)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_data(d8),
        .in_ready(rdy8), .cnt_valid(cv8), .cnt_o(cnt8),
        .code_valid(kv8), .code_o(code8), .len_o(len8),
        .mask_o(mask8), .oor_o(oor8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] p8(input int a, b, c, d, e, f);
        return {8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [23:0] p4(input int a, b, c, d, e, f);
        return {4'(f), 4'(e), 4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    task automatic push(input int v, input int n);
        repeat (n) q.push_back(8'(v));
    endtask

    task automatic mk_t1();
        q.delete();
        push(1, 30); push(2, 20); push(3, 15); push(4, 15); push(5, 10); push(6, 10);
    endtask

    task automatic mk_t2();
        q.delete();
        push(3, 100);
    endtask

    task automatic feed(input int gap);
        int i = 0;
        int guard = 0;
        while (i < q.size() && guard < 2000) begin
            @(negedge clk);
            in_valid = ($urandom_range(99) >= gap);
            in_data  = q[i];
            if (in_valid && in_ready) i++;
            guard++;
        end
        check("feed_done", i, q.size());
    endtask

    // Offers junk samples while the block is busy; they must not be counted.
    task automatic collect();
        int tc = -1;
        int tk = -1;
        for (int c = 0; c < 40 && tk < 0; c++) begin
            @(negedge clk);
            if (cnt_valid) begin
                tc = c;
                cap_cnt = cnt_o;
                check("rdy_init", in_ready, 0);
            end
            if (code_valid) begin
                tk = c;
                cap_code = code_o;
                cap_len  = len_o;
                cap_mask = mask_o;
                cap_oor  = oor_o;
                check("rdy_done", in_ready, 0);
            end
            in_valid = 1'b1;
            in_data  = 8'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("rdy_back", in_ready, 1);
        check("pulses_seen", {tc >= 0, tk >= 0}, 2'b11);
        lat = tk - tc;
    endtask

    task automatic expect_res(input string t, input logic [47:0] ecnt, ecode, emask,
                              input logic [23:0] elen, input logic eoor, input int elat);
        check({t, "_cnt"}, cap_cnt, ecnt);
        check({t, "_code"}, cap_code, ecode);
        check({t, "_len"}, cap_len, elen);
        check({t, "_mask"}, cap_mask, emask);
        check({t, "_oor"}, cap_oor, eoor);
        check({t, "_lat"}, lat, elat);
    endtask

    task automatic expect_t1(input string t);
        expect_res(t, p8(30, 20, 15, 15, 10, 10), p8(1, 3, 1, 0, 5, 4), p8(3, 3, 7, 7, 7, 7),
                   p4(2, 2, 3, 3, 3, 3), 1'b0, 11);
    endtask

    task automatic expect_t2(input string t);
        expect_res(t, p8(0, 0, 100, 0, 0, 0), '0, p8(0, 0, 1, 0, 0, 0),
                   p4(0, 0, 1, 0, 0, 0), 1'b0, 1);
    endtask

    initial begin
        int nq;
        int tc8;
        int tk8;
        logic [7:0] seen;
        repeat (2) @(negedge clk);
        check("rst_rdy", in_ready, 1);
        check("rst_flags", {cnt_valid, code_valid, oor_o}, 0);
        check("rst_cnt", cnt_o, 0);
        check("rst_code", code_o, 0);
        check("rst_len", len_o, 0);
        check("rst_mask", mask_o, 0);
        reset = 1'b0;

        mk_t1(); feed(0); collect(); expect_t1("skew");
        mk_t2(); feed(0); collect(); expect_t2("single");

        q.delete();
        push(0, 5); push(1, 20); push(2, 20); push(3, 15); push(4, 15); push(5, 10); push(6, 10); push(7, 5);
        feed(0); collect();
        expect_res("oor", p8(20, 20, 15, 15, 10, 10), p8(3, 2, 1, 0, 3, 2), p8(3, 3, 7, 7, 7, 7),
                   p4(2, 2, 3, 3, 3, 3), 1'b1, 11);
        mk_t1(); feed(0); collect(); expect_t1("clean");

        mk_t2(); feed(30); collect(); expect_t2("gap1");
        mk_t1(); feed(30); collect(); expect_t1("gap2");

        mk_t1(); feed(0);
        @(negedge clk);
        in_valid = 1'b0;
        check("mrg_cv", cnt_valid, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrg_rdy", in_ready, 1);
        check("mrg_flags", {cnt_valid, code_valid, oor_o}, 0);
        check("mrg_cnt", cnt_o, 0);
        check("mrg_code", code_o, 0);
        check("mrg_len", len_o, 0);
        check("mrg_mask", mask_o, 0);
        @(negedge clk);
        reset = 1'b0;
        nq = 0;
        repeat (30) begin
            @(negedge clk);
            if (code_valid) nq++;
        end
        check("mrg_nopulse", nq, 0);
        mk_t2(); feed(0); collect(); expect_t2("after_rst");

        tc8 = -1;
        tk8 = -1;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            v8 = 1'b1;
            d8 = 8'(i % 8 + 1);
        end
        for (int c = 0; c < 40 && tk8 < 0; c++) begin
            @(negedge clk);
            v8 = 1'b0;
            if (cv8) begin
                tc8 = c;
                check("n8_cnt", cnt8, 64'h0C0C_0C0C_0C0C_0C0C);
            end
            if (kv8) begin
                tk8 = c;
                check("n8_len", len8, 32'h3333_3333);
                check("n8_mask", mask8, 64'h0707_0707_0707_0707);
                seen = '0;
                for (int s = 0; s < 8; s++) seen = seen | (8'd1 << code8[s*8 +: 8]);
                check("n8_cover", seen, 8'hFF);
            end
        end
        check("n8_pulses", {tc8 >= 0, tk8 >= 0}, 2'b11);
        check("n8_lat", tk8 - tc8, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
